// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RISC-V byte/half/word load-store stage over a req/ack data bus.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam logic [1:0]       S_IDLE     = 2'd0;
  localparam logic [1:0]       S_REQ      = 2'd1;
  localparam logic [1:0]       S_DONE     = 2'd2;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic [31:0]      r_load;
  logic             r_done;
  logic             r_mis;
  logic             r_fault;

  logic             w_access;
  logic             w_illegal;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load;

  assign w_access = mem_read | mem_write;

  // A store beats a simultaneous load, so only mem_write selects the store rules.
  always_comb begin
    w_illegal = (funct3[1:0] == 2'b11)
              | ((funct3[1:0] == 2'b01) & addr[0])
              | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00))
              | (mem_write & funct3[2]);
    w_be    = 4'b1111;
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_wdata = {4{store_data[7:0]}};
        if (mem_write) w_be = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{store_data[15:0]}};
        if (mem_write) w_be = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = store_data;
        w_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_off)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3[1:0])
      2'b00:   w_load = r_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_be     <= 4'd0;
      r_load   <= 32'd0;
      r_done   <= 1'b0;
      r_mis    <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_illegal) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_mis   <= 1'b1;
              r_load  <= 32'd0;
            end else begin
              r_state  <= S_REQ;
              r_cnt    <= '0;
              r_funct3 <= funct3;
              r_off    <= addr[1:0];
              r_we     <= mem_write;
              r_addr   <= {addr[31:2], 2'b00};
              r_wdata  <= w_wdata;
              r_be     <= w_be;
            end
          end
        end
        S_REQ: begin
          // Ack is tested first so a last-cycle ack still completes normally.
          if (dmem_ack) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_load  <= r_we ? 32'd0 : w_load;
          end else if (r_cnt == C_CNT_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_fault <= 1'b1;
            r_load  <= 32'd0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall      = ((r_state == S_IDLE) & w_access) | (r_state == S_REQ);
  assign dmem_req   = (r_state == S_REQ);
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;
  assign load_data  = r_load;
  assign done       = r_done;
  assign misaligned = r_mis;
  assign bus_fault  = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, dmem_rdata;
  logic        dmem_ack;
  logic [31:0] load_data, dmem_addr, dmem_wdata;
  logic        done, stall, misaligned, bus_fault, dmem_req, dmem_we;
  logic [3:0]  dmem_be;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .load_data(load_data), .done(done), .stall(stall),
    .misaligned(misaligned), .bus_fault(bus_fault), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  // expected outputs for the current cycle
  logic        chk_en = 1'b0, probe = 1'b0;
  logic        e_stall, e_req, e_done, e_mis, e_fault, e_bus, e_wd, e_we, lit_en;
  logic [31:0] e_ld, e_addr, e_wdata, lit_ld;
  logic [3:0]  e_be;
  int          total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk or posedge probe) begin
    if (probe) begin
      chk("async_req", {31'd0, dmem_req}, 32'd0);
      chk("async_stall", {31'd0, stall}, 32'd0);
    end else if (chk_en) begin
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("dmem_req", {31'd0, dmem_req}, {31'd0, e_req});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("misaligned", {31'd0, misaligned}, {31'd0, e_mis});
      chk("bus_fault", {31'd0, bus_fault}, {31'd0, e_fault});
      chk("load_data", load_data, e_ld);
      if (e_bus) begin
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, e_we});
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_be", {28'd0, dmem_be}, {28'd0, e_be});
        if (e_wd) chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      if (lit_en) chk("literal_load_data", load_data, lit_ld);
    end
  end

  // ---------------- reference model (RISC-V access semantics) --------------
  function automatic int m_size(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit m_legal(input logic wr, input logic [2:0] f, input logic [31:0] a);
    int s = m_size(f);
    int off = int'(a[1:0]);
    if (s == 8) return 1'b0;
    if ((off % s) != 0) return 1'b0;
    if (wr && f[2]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_be(input logic wr, input logic [2:0] f, input logic [31:0] a);
    logic [3:0] be;
    int s = m_size(f);
    int base = int'(a[1:0]) - (int'(a[1:0]) % s);
    for (int i = 0; i < 4; i++) be[i] = !wr || (i >= base && i < base + s);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] sd);
    logic [31:0] w;
    int s = m_size(f);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] rd);
    int s = m_size(f);
    logic [31:0] v, mask;
    if (s == 4) return rd;
    v    = rd >> (8 * int'(a[1:0]));
    mask = (32'd1 << (8 * s)) - 32'd1;
    v    = v & mask;
    if (!f[2] && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_stall = 1'b0; e_req = 1'b0; e_done = 1'b0; e_mis = 1'b0; e_fault = 1'b0;
    e_bus = 1'b0; e_wd = 1'b0; lit_en = 1'b0;
  endtask

  // ack_at = REQ cycle number carrying the ack; 0 means never acknowledged
  task automatic txn(input logic rd, input logic wr, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] rdata, input int ack_at,
                     input logic use_lit, input logic [31:0] lit);
    int n_req;
    mem_read = rd; mem_write = wr; funct3 = f; addr = a; store_data = sd;
    set_idle_exp();
    e_stall = 1'b1;
    next();
    if (!m_legal(wr, f, a)) begin
      set_idle_exp();
      e_done = 1'b1; e_mis = 1'b1; e_ld = 32'd0;
    end else begin
      n_req = (ack_at > 0) ? ack_at : TO;
      for (int n = 1; n <= n_req; n++) begin
        e_req = 1'b1; e_stall = 1'b1; e_bus = 1'b1; e_wd = wr; e_we = wr;
        e_addr = {a[31:2], 2'b00}; e_be = m_be(wr, f, a); e_wdata = m_wdata(f, sd);
        dmem_ack   = (n == ack_at);
        dmem_rdata = (n == ack_at) ? rdata : 32'h5A5A_5A5A;
        next();
      end
      dmem_ack = 1'b0;
      set_idle_exp();
      e_done  = 1'b1;
      e_fault = (ack_at == 0);
      e_ld    = ((ack_at == 0) || wr) ? 32'd0 : m_load(f, a, rdata);
    end
    lit_en = use_lit; lit_ld = lit;
    next();
    mem_read = 1'b0; mem_write = 1'b0;
    set_idle_exp();
    next();
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0; dmem_rdata = 32'd0; dmem_ack = 1'b0;
    set_idle_exp();
    e_ld = 32'd0; e_bus = 1'b1; e_wd = 1'b1; e_we = 1'b0;
    e_addr = 32'd0; e_be = 4'd0; e_wdata = 32'd0; lit_ld = 32'd0;
    chk_en = 1'b1;
    next(); next();
    reset = 1'b0;
    set_idle_exp();
    next();

    // zero-wait word load
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1, 1'b1, 32'hDEAD_BEEF);
    // byte store, 3 wait states
    txn(1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'd0, 4, 1'b1, 32'd0);
    // sign / zero extension
    txn(1'b1, 1'b0, 3'b000, 32'h0000_0400, 32'd0, 32'h80F0_7F81, 1, 1'b1, 32'hFFFF_FF81);
    txn(1'b1, 1'b0, 3'b100, 32'h0000_0402, 32'd0, 32'h80F0_7F81, 2, 1'b1, 32'h0000_00F0);
    txn(1'b1, 1'b0, 3'b001, 32'h0000_0402, 32'd0, 32'h80F0_7F81, 1, 1'b1, 32'hFFFF_80F0);
    txn(1'b1, 1'b0, 3'b101, 32'h0000_0400, 32'd0, 32'h80F0_7F81, 1, 1'b1, 32'h0000_7F81);
    txn(1'b1, 1'b0, 3'b000, 32'h0000_0401, 32'd0, 32'h1234_8056, 1, 1'b1, 32'hFFFF_FF80);
    // halfword/word stores, and store winning over a simultaneous load
    txn(1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'hCAFE_1234, 32'd0, 1, 1'b0, 32'd0);
    txn(1'b0, 1'b1, 3'b010, 32'h0000_0208, 32'hCAFE_1234, 32'd0, 2, 1'b0, 32'd0);
    txn(1'b1, 1'b1, 3'b000, 32'h0000_0209, 32'h0000_0077, 32'hFFFF_FFFF, 1, 1'b1, 32'd0);
    // illegal accesses
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'd0, 1, 1'b1, 32'd0);
    txn(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'd0, 32'd0, 1, 1'b0, 32'd0);
    txn(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'd0, 32'd0, 1, 1'b0, 32'd0);
    txn(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 1, 1'b0, 32'd0);
    // timeout, then ack on the final permitted cycle
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0, 32'd0, 0, 1'b1, 32'd0);
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0504, 32'd0, 32'h0BAD_F00D, TO, 1'b1, 32'h0BAD_F00D);

    // asynchronous reset on the second REQ cycle
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300;
    set_idle_exp(); e_stall = 1'b1;
    next();
    e_req = 1'b1; e_bus = 1'b1; e_wd = 1'b0; e_we = 1'b0;
    e_addr = 32'h0000_0300; e_be = 4'hF;
    next();
    #1 reset = 1'b1; mem_read = 1'b0;
    set_idle_exp();
    e_ld = 32'd0; e_bus = 1'b1; e_wd = 1'b1; e_we = 1'b0;
    e_addr = 32'd0; e_be = 4'd0; e_wdata = 32'd0;
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    next();
    reset = 1'b0;
    set_idle_exp();
    next(); next();
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'd0, 32'h1357_9BDF, 1, 1'b1, 32'h1357_9BDF);

    chk_en = 1'b0;
    next();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU. It takes the ALU result as the effective address, performs RISC-V byte, halfword and word loads and stores over a req/ack data-memory handshake, and returns sign- or zero-extended load data for writeback. While an access is in flight it holds the core with `stall`. It flags misaligned or illegal accesses, and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, maximum number of cycles in REQ without `dmem_ack` before the access is aborted with `bus_fault`.
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
mem_read  in  1  load request from the current instruction
mem_write  in  1  store request from the current instruction
funct3  in  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
addr  in  32  effective address (ALU result)
store_data  in  32  rs2 value
load_data  out  32  extended load result, valid while done=1
done  out  1  one-cycle completion pulse
stall  out  1  holds the PC and pipeline while high
misaligned  out  1  one-cycle pulse with done: misaligned or illegal access
bus_fault  out  1  one-cycle pulse with done: timeout expired
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address, {addr[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_rdata  in  32  read word
dmem_ack  in  1  memory accepted (write) or data valid (read)

Behaviour:
- Clocking and reset:
  - One clock domain.
  - `reset` asynchronous, active-high. It forces state IDLE and clears the counter.
  - All registered outputs go to 0, including dmem_req/dmem_we/dmem_be/dmem_addr/dmem_wdata, load_data, done, misaligned and bus_fault.
  - Reset mid-access drops dmem_req immediately; no completion is reported.
- States: IDLE, REQ, DONE.
- IDLE:
  - If mem_read or mem_write is high, decode the access.
  - If both are high, the store wins.
  - Legal access: latch addr, we, be and wdata into the dmem registers, then go to REQ.
  - Illegal access: go to DONE with misaligned=1 and no bus request. Illegal means funct3[1:0]=11, or halfword with addr[0]=1, or word with addr[1:0]!=00, or a store with funct3[2]=1.
- REQ:
  - dmem_req=1, with addr/we/be/wdata held stable.
  - The counter increments each cycle.
  - On dmem_ack: capture and extract the read data, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: go to DONE with bus_fault=1 and load_data=0.
  - If ack arrives in the same cycle as the timeout, ack wins.
- DONE:
  - One cycle: done=1, misaligned/bus_fault as set, dmem_req=0.
  - Inputs are ignored, since the same instruction is still presented.
  - Return to IDLE.
- stall: combinational, `(IDLE & (mem_read|mem_write)) | REQ`. stall=0 in DONE, so the core advances on that edge.
- Latency: a zero-wait-state ack gives done 2 cycles after the request is first seen in IDLE.
- Store lanes:
  - sb: be = 4'b0001 << addr[1:0], wdata = {4{store_data[7:0]}}.
  - sh: be = 4'b0011 << {addr[1],1'b0}, wdata = {2{store_data[15:0]}}.
  - sw: be = 4'b1111, wdata = store_data.
- Load extraction uses lane addr[1:0] or addr[1]:
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
  - For loads, be = 1111 regardless of size.
- load_data holds its value until the next completion. On a store completion it is 0.

Test Plan:
- Zero-wait word load: addr=0x100, funct3=010, ack on the first REQ cycle with rdata=0xDEADBEEF. Required: dmem_addr=0x100, be=1111, done pulses 2 cycles later, load_data=0xDEADBEEF, stall high for exactly 2 cycles.
- Byte store with 3 wait states: addr=0x203, funct3=000, store_data=0x000000A5. Required: be=1000, wdata=0xA5A5A5A5, dmem_addr=0x200, dmem_req held for 4 cycles, done follows, load_data=0.
- Load sign/zero extension: rdata=0x80F0_7F81. lb@addr[1:0]=00 gives 0xFFFFFF81; lbu@10 gives 0x000000F0; lh@10 gives 0xFFFF80F0; lhu@00 gives 0x00007F81.
- Misaligned access: lw@0x102 or lh@0x101. Required: dmem_req never asserted, done=1 and misaligned=1 on the cycle after the request, stall=0 in that cycle.
- Timeout: ack never asserted with TIMEOUT_CYCLES=16. Required: dmem_req high for 16 cycles, then done=1, bus_fault=1, load_data=0. Repeat with ack on the 16th cycle: required success with bus_fault=0.
- Reset mid-REQ: assert reset asynchronously on the 2nd REQ cycle. Required: dmem_req falls without waiting for a clock edge, no done pulse, and after release the unit is IDLE and accepts a new lw normally.
